instr_loader: RTL

Program loader that sits on the instruction-memory write side, ahead of the CPU. It accepts field-level RV32I instruction descriptions over a valid/ready stream and encodes each one into a 32-bit instruction word. This is the inverse of the instruction decoder. Each encoded word is written into instruction RAM at consecutive word addresses, and the loader holds the CPU in reset until the program is fully written.

---
 rtl/instr_pkg.sv | 18 +
 rtl/riscv_32_instr_encoder.sv | 41 ++++
 rtl/instr_loader.sv | 98 +++++++++
 3 files changed

// File: rtl/instr_pkg.sv
// instr_pkg: shared RV32I format enum, NOP word and loader state enum
package instr_pkg;
  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5
  } fmt_e;
  localparam logic [31:0] NOP_WORD = 32'h00000013;
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOAD   = 2'd1,
    S_WRITE  = 2'd2,
    S_FINISH = 2'd3
  } state_e;
endpackage

// File: rtl/riscv_32_instr_encoder.sv
// riscv_32_instr_encoder: combinational RV32I field encoder; immediate range check under INSTR_LOADER_RANGE_CHECK_EN
module riscv_32_instr_encoder
  import instr_pkg::*;
(
  input  logic [2:0]  fmt,
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [31:0] imm,
  output logic [31:0] word,
  output logic        illegal,
  output logic        range_err
);
  // place fields per format; illegal formats collapse to a NOP
  always_comb begin
    illegal = fmt > 3'd5;
    word = fmt == FMT_R ? {funct7, rs2, rs1, funct3, rd, opcode} :
           fmt == FMT_I ? {imm[11:0], rs1, funct3, rd, opcode} :
           fmt == FMT_S ? {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode} :
           fmt == FMT_B ? {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode} :
           fmt == FMT_U ? {imm[31:12], rd, opcode} :
           fmt == FMT_J ? {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode} :
           NOP_WORD;
  end
`ifdef INSTR_LOADER_RANGE_CHECK_EN
  // the upper bits must be pure sign extension of the field's top bit
  logic fit12, fit13, fit21;
  assign fit12 = &imm[31:11] | ~|imm[31:11];
  assign fit13 = &imm[31:12] | ~|imm[31:12];
  assign fit21 = &imm[31:20] | ~|imm[31:20];
  assign range_err = (fmt == FMT_I || fmt == FMT_S) ? !fit12 :
                     fmt == FMT_B ? (!fit13 || imm[0]) :
                     fmt == FMT_J ? (!fit21 || imm[0]) :
                     fmt == FMT_U ? |imm[11:0] : 1'b0;
`else
  assign range_err = 1'b0;
`endif
endmodule

// File: rtl/instr_loader.sv
// instr_loader: streams encoded RV32I words into instruction RAM, holding the CPU in reset meanwhile (INSTR_LOADER_RANGE_CHECK_EN enables immediate range errors)
module instr_loader
  import instr_pkg::*;
#(
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              res,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_fmt,
  input  logic [6:0]        in_opcode,
  input  logic [2:0]        in_funct3,
  input  logic [6:0]        in_funct7,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [31:0]       in_imm,
  input  logic              in_last,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic [ADDR_W:0]   word_count,
  output logic              err
);
  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              last_q, last_d, err_q, err_d;
  logic [31:0]       enc_word;
  logic              enc_illegal, enc_range;
  riscv_32_instr_encoder u_enc (
    .fmt(in_fmt), .opcode(in_opcode), .funct3(in_funct3), .funct7(in_funct7),
    .rd(in_rd), .rs1(in_rs1), .rs2(in_rs2), .imm(in_imm),
    .word(enc_word), .illegal(enc_illegal), .range_err(enc_range)
  );
  assign in_ready   = state_q == S_LOAD;
  assign mem_we     = state_q == S_WRITE;
  assign done       = state_q == S_FINISH;
  assign cpu_hold   = state_q != S_IDLE;
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;
  assign word_count = count_q;
  assign err        = err_q;
  // next-state: accept a beat in LOAD, commit it in WRITE, wrap counter flags err
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    count_d = count_q;
    last_d  = last_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: if (start) begin
        state_d = S_LOAD;
        addr_d  = base_addr;
        count_d = '0;
        err_d   = 1'b0;
      end
      S_LOAD: if (in_valid) begin
        state_d = S_WRITE;
        wdata_d = enc_word;
        last_d  = in_last;
        err_d   = err_q | enc_illegal | enc_range;
      end
      S_WRITE: begin
        state_d = last_q ? S_FINISH : S_LOAD;
        addr_d  = addr_q + (ADDR_W)'(1);
        count_d = count_q + (ADDR_W+1)'(1);
        err_d   = err_q | (&addr_q);
      end
      default: state_d = S_IDLE;
    endcase
  end
  // state registers, async reset clears everything
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      count_q <= '0;
      last_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      count_q <= count_d;
      last_q  <= last_d;
      err_q   <= err_d;
    end
  end
endmodule
